// File: rtl/ram_burst_controller.sv
// Burst initiator for the 8-bit dual-port memory: streams write bursts in,
// fetches read bursts out with a 3-cycle request/capture/hold beat.
module ram_burst_controller #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 512,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic [ADDR_W-1:0] mem_read_address,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_CAP,
        RD_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              mw_q, mw_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_nx;
    logic              cmd_bad;

    // Wrap inside the implemented depth, never past it
    assign addr_nx = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
    assign cmd_bad = 32'(cmd_addr) >= DEPTH;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        mw_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        raddr_d  = raddr_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    cnt_d  = cmd_len;
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else if (cmd_rw) begin
                        state_d = WR;
                    end else begin
                        raddr_d = cmd_addr;
                        state_d = RD_REQ;
                    end
                end
            end
            WR: begin
                if (wr_valid) begin
                    mw_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = wr_data;
                    addr_d  = addr_nx;
                    if (cnt_q == '0) state_d = IDLE;
                    else cnt_d = cnt_q - 1'b1;
                end
            end
            RD_REQ: state_d = RD_CAP;
            RD_CAP: begin
                rvalid_d = 1'b1;
                rdata_d  = mem_data_out;
                state_d  = RD_HOLD;
            end
            RD_HOLD: begin
                if (rd_ready) begin
                    rvalid_d = 1'b0;
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                        addr_d  = addr_nx;
                        raddr_d = addr_nx;
                        state_d = RD_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            mw_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            raddr_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            mw_q     <= mw_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            raddr_q  <= raddr_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign cmd_ready         = (state_q == IDLE);
    assign wr_ready          = (state_q == WR);
    assign busy              = (state_q != IDLE);
    assign mem_write         = mw_q;
    assign mem_write_address = waddr_q;
    assign mem_data_in       = wdata_q;
    assign mem_read_address  = raddr_q;
    assign rd_valid          = rvalid_q;
    assign rd_data           = rdata_q;
    assign err               = err_q;

endmodule

// File: tb/tb_ram_burst_controller.sv
// Scoreboard bench for ram_burst_controller with a behavioural
// dual-port memory (1-cycle registered read).
module tb_ram_burst_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [9:0] cmd_addr = '0;
    logic [7:0] cmd_len = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = '0;
    logic       rd_valid;
    logic       rd_ready = 1'b1;
    logic [7:0] rd_data;
    logic       mem_write;
    logic [9:0] mem_write_address;
    logic [7:0] mem_data_in;
    logic [9:0] mem_read_address;
    logic [7:0] mem_data_out = '0;
    logic       busy;
    logic       err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0]  mem [0:1023];
    logic [17:0] wq[$];
    logic [7:0]  rq[$];
    int          hs_cyc[$];

    ram_burst_controller dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .mem_write(mem_write), .mem_write_address(mem_write_address),
        .mem_data_in(mem_data_in), .mem_read_address(mem_read_address),
        .mem_data_out(mem_data_out), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        mem_data_out <= mem[mem_read_address];
        if (mem_write === 1'b1) mem[mem_write_address] = mem_data_in;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or hands out a beat
    always @(negedge clk) begin
        logic [17:0] e;
        if (mem_write === 1'b1) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         mem_write_address, mem_data_in);
            end else begin
                e = wq.pop_front();
                chk("wr_addr", 32'(mem_write_address), 32'(e[17:8]));
                chk("wr_data", 32'(mem_data_in), 32'(e[7:0]));
            end
        end
        if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
            hs_cyc.push_back(cyc);
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got %0h expected none", rd_data);
            end else begin
                chk("rd_data", 32'(rd_data), 32'(rq.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic rw, input logic [9:0] a,
                            input logic [7:0] len);
        int t = 0;
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = a;
        cmd_len   = len;
        while (cmd_ready !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (busy !== 1'b0 && t < 200) begin
            tick();
            t++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic do_write(input logic [9:0] a, input logic [7:0] len,
                            input logic [15:0] pat, input int n,
                            input logic [31:0] data);
        logic [9:0] ac;
        logic       prev;
        int         j;
        ac = a;
        j  = 0;
        for (int i = 0; i < n; i++) begin
            if (pat[i]) begin
                wq.push_back({ac, data[8*j +: 8]});
                ac = (ac == 10'd511) ? 10'd0 : ac + 10'd1;
                j++;
            end
        end
        send_cmd(1'b1, a, len);
        j    = 0;
        prev = 1'b0;
        for (int i = 0; i < n; i++) begin
            wr_valid = pat[i];
            wr_data  = pat[i] ? data[8*j +: 8] : 8'hEE;
            if (pat[i]) j++;
            @(negedge clk);
            chk("wr_ready", 32'(wr_ready), 32'd1);
            chk("mw_timing", 32'(mem_write), 32'(prev));
            prev = pat[i];
            tick();
        end
        wr_valid = 1'b0;
        @(negedge clk);
        chk("mw_last", 32'(mem_write), 32'(prev));
        chk("wr_busy_done", 32'(busy), 32'd0);
        tick();
        @(negedge clk);
        chk("mw_after", 32'(mem_write), 32'd0);
        tick();
    endtask

    task automatic do_read(input logic [9:0] a, input logic [7:0] len,
                           input logic [31:0] exp);
        for (int i = 0; i <= int'(len); i++) rq.push_back(exp[8*i +: 8]);
        hs_cyc.delete();
        rd_ready = 1'b1;
        send_cmd(1'b0, a, len);
        wait_idle("rd_done");
        chk("rd_valid_idle", 32'(rd_valid), 32'd0);
        chk("rd_beats", 32'(hs_cyc.size()), 32'(len) + 32'd1);
        if (hs_cyc.size() == int'(len) + 1)
            for (int i = 1; i <= int'(len); i++)
                chk("beat_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd3);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mw", 32'(mem_write), 32'd0);
        chk("rst_rvalid", 32'(rd_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_raddr", 32'(mem_read_address), 32'd0);
        tick();

        do_write(10'h010, 8'd3, 16'b1111, 4, 32'hA3A2A1A0);
        do_read(10'h010, 8'd3, 32'hA3A2A1A0);

        do_write(10'h1FE, 8'd3, 16'b1111, 4, 32'h44332211);
        do_read(10'h1FE, 8'd3, 32'h44332211);

        rq.push_back(8'hA0);
        rq.push_back(8'hA1);
        rd_ready = 1'b0;
        send_cmd(1'b0, 10'h010, 8'd1);
        t = 0;
        while (rd_valid !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        chk("bp_valid_wait", 32'(rd_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(rd_valid), 32'd1);
            chk("bp_data", 32'(rd_data), 32'hA0);
            chk("bp_raddr", 32'(mem_read_address), 32'h010);
            tick();
        end
        rd_ready = 1'b1;
        wait_idle("bp_done");

        do_write(10'h040, 8'd2, 16'b101001, 6, 32'h00C3C2C1);
        do_read(10'h040, 8'd2, 32'h00C3C2C1);

        cmd_valid = 1'b1;
        cmd_rw    = 1'b1;
        cmd_addr  = 10'h200;
        cmd_len   = 8'd0;
        @(negedge clk);
        chk("ill_ready_pre", 32'(cmd_ready), 32'd1);
        chk("ill_err_pre", 32'(err), 32'd0);
        tick();
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_busy", 32'(busy), 32'd0);
        chk("ill_ready", 32'(cmd_ready), 32'd1);
        tick();
        @(negedge clk);
        chk("ill_err_clr", 32'(err), 32'd0);
        chk("ill_busy2", 32'(busy), 32'd0);
        tick();

        wq.push_back({10'h080, 8'h55});
        wq.push_back({10'h081, 8'h66});
        send_cmd(1'b1, 10'h080, 8'd3);
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        tick();
        wr_data = 8'h66;
        tick();
        rst     = 1'b1;
        wr_data = 8'h77;
        tick();
        rst      = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("rstw_mw", 32'(mem_write), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_ready", 32'(cmd_ready), 32'd1);
        chk("rstw_rvalid", 32'(rd_valid), 32'd0);
        tick();
        do_read(10'h080, 8'd3, 32'hD9D86655);

        repeat (3) tick();
        chk("wq_empty", 32'(wq.size()), 32'd0);
        chk("rq_empty", 32'(rq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_burst_controller.md
Name: ram_burst_controller

Overview:
- Initiator-side controller for the team's 8-bit dual-port memory block (write port: write/write_address/data_in; read port: read_address/data_out with 1-cycle registered latency).
- Accepts burst commands over a valid/ready handshake.
- Write bursts move bytes from an input stream into the memory; read bursts fetch bytes from the memory onto an output stream with backpressure.
- Sits between stream producers/consumers and the memory; it is the only driver of the memory's ports.

Parameters:
- DATA_W, 8, data byte width
- ADDR_W, 10, memory address port width
- DEPTH, 512, number of implemented memory locations; valid addresses are 0..DEPTH-1
- LEN_W, 8, burst length field width; the burst carries cmd_len+1 beats (1..256)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_rw  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  burst start address
- cmd_len  in  LEN_W  beats minus one
- wr_valid  in  1  write beat present
- wr_ready  out  1  write beat accepted
- wr_data  in  DATA_W  write beat data
- rd_valid  out  1  read beat present
- rd_ready  in  1  consumer accepts read beat
- rd_data  out  DATA_W  read beat data
- mem_write  out  1  to memory write
- mem_write_address  out  ADDR_W  to memory write_address
- mem_data_in  out  DATA_W  to memory data_in
- mem_read_address  out  ADDR_W  to memory read_address
- mem_data_out  in  DATA_W  from memory data_out
- busy  out  1  high whenever state != IDLE
- err  out  1  one-cycle pulse on a rejected command

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- All outputs are registered except cmd_ready, wr_ready and busy, which decode the state.
- Reset values: all registered outputs 0; state IDLE.
- States: IDLE, WR, RD_REQ, RD_CAP, RD_HOLD.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr=cmd_addr and cnt=cmd_len.
  - If cmd_addr >= DEPTH: err=1 for the next cycle only, no memory access, stay IDLE.
  - Otherwise go to WR if cmd_rw=1, else RD_REQ.
- WR:
  - wr_ready=1.
  - On wr_valid at edge k, during cycle k+1: mem_write=1, mem_write_address=addr, mem_data_in=wr_data.
  - The memory commits at edge k+1.
  - Cycles without a handshake drive mem_write=0.
  - Each beat advances addr; on the beat with cnt==0, return to IDLE. mem_write may still be high for that one following cycle.
- Read, per beat:
  - RD_REQ: mem_read_address=addr, mem_write=0.
  - RD_CAP: memory output settles.
  - At the end of RD_CAP, capture rd_data=mem_data_out and set rd_valid=1.
  - RD_HOLD: rd_valid and rd_data stay stable until rd_ready. On the handshake, rd_valid=0 next cycle.
  - After the handshake: if cnt==0 go to IDLE, else decrement cnt, advance addr, go to RD_REQ.
  - Throughput is one read beat per 3 cycles when rd_ready is held high.
  - mem_write stays 0 and mem_read_address stays constant through RD_REQ, RD_CAP and RD_HOLD.
- Address advance: addr = (addr == DEPTH-1) ? 0 : addr+1. Wraps within DEPTH; never drives an address >= DEPTH.
- cmd_ready is 0 outside IDLE. Commands presented while busy are not accepted and are held by the source.
- Back-to-back: a new command may be accepted in the first IDLE cycle after a burst completes.
- Reset mid-burst:
  - Next cycle: mem_write=0, rd_valid=0, state IDLE.
  - Remaining beats are abandoned; no further memory writes.
  - Data already written is retained.
- mem_read_address holds its last value in IDLE and WR.

Test Plan:
- Write cmd addr 0x010 len 3, data A0,A1,A2,A3 with wr_valid held high -> mem_write high 4 consecutive cycles at 0x010..0x013. Then read cmd 0x010 len 3 with rd_ready=1 -> rd_data A0..A3, each beat 3 cycles apart; busy low afterwards.
- Wrap: write 0x1FE len 3, data 11,22,33,44 -> write addresses 0x1FE,0x1FF,0x000,0x001. Read 0x1FE len 3 -> 11,22,33,44.
- Backpressure: read 0x010 len 1 with rd_ready low 5 cycles on the first beat -> rd_valid high and rd_data=A0 stable; mem_read_address stays 0x010. After release, the second beat = A1.
- Write gaps: write 0x040 len 2 with wr_valid pattern 1,0,0,1,0,1 -> mem_write pulses only the cycle after each handshake, at 0x040,0x041,0x042.
- Illegal address: cmd_addr 0x200 -> err=1 exactly one cycle, mem_write never asserted, cmd_ready=1 throughout, busy stays 0.
- Reset mid-write: write 0x080 len 3, assert rst after 2 handshakes -> mem_write=0 the cycle after rst. Readback shows only 0x080 and 0x081 modified. cmd_ready=1 after rst deasserts.
